// File: rtl/sample_rr_sched_pkg.sv
// Shared types and helpers for the round-robin sample scheduler.
package sample_sched_pkg;

    // Output register occupancy: EMPTY holds nothing, OFFER presents a beat.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_OFFER = 1'b1
    } out_state_e;

    // Channel-id width, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sample_rr_sched_if.sv
// Sample-in / beat-out bundle between N producers, the scheduler and one consumer.
interface sample_rr_sched_if #(
    parameter int N   = 2,
    parameter int DIN = 16
);
    import sample_sched_pkg::*;

    localparam int W = id_width(N);

    logic [N-1:0]       din_valid;
    logic [N-1:0]       din_ready;
    logic [N*DIN-1:0]   din_data;
    logic               dout_valid;
    logic               dout_ready;
    logic [W+DIN-1:0]   dout_data;
    logic [N-1:0]       overrun;

    // Environment side: producers and consumer.
    modport master (
        output din_valid, din_data, dout_ready,
        input  din_ready, dout_valid, dout_data, overrun
    );

    // Scheduler side.
    modport slave (
        input  din_valid, din_data, dout_ready,
        output din_ready, dout_valid, dout_data, overrun
    );

endinterface

// File: rtl/sample_rr_pick.sv
// Rotating-priority encoder: first eligible channel at or after ptr, wrapping.
module sample_rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         any
);

    // Scan ptr, ptr+1, ... N-1, 0, ...; the first hit wins. ptr < N, so one
    // subtraction of N is enough to wrap and W+1 bits hold the sum.
    always_comb begin
        logic [W:0]   sum;
        logic [W-1:0] sel;
        grant = '0;
        any   = 1'b0;
        sum   = '0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (W+1)'(k);
            if (sum >= (W+1)'(N))
                sum = sum - (W+1)'(N);
            sel = sum[W-1:0];
            if (!any && eligible[sel]) begin
                any   = 1'b1;
                grant = sel;
            end
        end
    end

endmodule

// File: rtl/sample_rr_sched.sv
// Round-robin scheduler: N latest-sample channels share one {id,data} output.
module sample_rr_sched
    import sample_sched_pkg::*;
#(
    parameter int N          = 2,
    parameter int DIN        = 16,
    parameter bit FRESH_ONLY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    sample_rr_sched_if.slave  bus
);

    localparam int W = id_width(N);

    typedef struct packed {
        logic [W-1:0]   id;
        logic [DIN-1:0] data;
    } beat_t;

    logic [N-1:0][DIN-1:0] chan_q;
    logic [N-1:0]          fresh_q;
    logic [N-1:0]          seen_q;
    logic [N-1:0]          overrun_q;
    logic [N-1:0]          eligible;
    logic [N-1:0]          grant_oh;
    logic [W-1:0]          ptr_q;
    logic [W-1:0]          grant;
    logic                  any;
    logic                  load;
    logic                  take;
    beat_t                 out_q;
    out_state_e            state_q;
    out_state_e            state_d;

    // Eligibility only looks at registered state, so a sample is never
    // granted in the same cycle it arrives.
    assign eligible = FRESH_ONLY ? fresh_q : seen_q;

    sample_rr_pick #(.N(N), .W(W)) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .grant    (grant),
        .any      (any)
    );

    // Output register may be refilled when empty or when its beat is taken.
    assign load     = (state_q == OUT_EMPTY) || bus.dout_ready;
    assign take     = load && any;
    assign grant_oh = take ? ({{(N-1){1'b0}}, 1'b1} << grant) : '0;

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= OUT_EMPTY;
        else
            state_q <= state_d;
    end

    // Occupancy next state: a load either refills or empties; otherwise hold.
    always_comb begin
        state_d = state_q;
        if (load)
            state_d = any ? OUT_OFFER : OUT_EMPTY;
    end

    // Offered beat and rotation pointer advance only on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            ptr_q <= '0;
        end else if (take) begin
            out_q <= '{id: grant, data: chan_q[grant]};
            ptr_q <= (grant == W'(N-1)) ? '0 : grant + W'(1);
        end
    end

    // Channel capture and bookkeeping. A new sample arriving on the channel
    // being granted wins over the grant's clear of fresh: the old value goes
    // out now and the new one on the channel's next turn, so nothing is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan_q    <= '0;
            fresh_q   <= '0;
            seen_q    <= '0;
            overrun_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.din_valid[i]) begin
                    chan_q[i]  <= bus.din_data[i*DIN +: DIN];
                    seen_q[i]  <= 1'b1;
                    fresh_q[i] <= 1'b1;
                    if (fresh_q[i] && !grant_oh[i])
                        overrun_q[i] <= 1'b1;
                end else if (grant_oh[i]) begin
                    fresh_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.din_ready  = '1;
    assign bus.dout_valid = (state_q == OUT_OFFER);
    assign bus.dout_data  = out_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_sample_rr_sched.sv
// Bench for sample_rr_sched: FRESH_ONLY=1 and FRESH_ONLY=0 instances share stimulus.
module tb_sample_rr_sched;

    localparam int N   = 3;
    localparam int DIN = 8;
    localparam int W   = 2;
    localparam int BW  = W + DIN;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     dv;
    logic [N*DIN-1:0] dd;
    logic             rdy;

    always #5 clk = ~clk;

    sample_rr_sched_if #(.N(N), .DIN(DIN)) bus0 ();
    sample_rr_sched_if #(.N(N), .DIN(DIN)) bus1 ();

    assign bus0.din_valid  = dv;
    assign bus0.din_data   = dd;
    assign bus0.dout_ready = rdy;
    assign bus1.din_valid  = dv;
    assign bus1.din_data   = dd;
    assign bus1.dout_ready = rdy;

    sample_rr_sched #(.N(N), .DIN(DIN), .FRESH_ONLY(1'b1)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    sample_rr_sched #(.N(N), .DIN(DIN), .FRESH_ONLY(1'b0)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    logic          obs_v[2];
    logic [BW-1:0] obs_d[2];
    logic [N-1:0]  obs_o[2];
    logic [N-1:0]  obs_r[2];

    assign obs_v[0] = bus0.dout_valid;
    assign obs_d[0] = bus0.dout_data;
    assign obs_o[0] = bus0.overrun;
    assign obs_r[0] = bus0.din_ready;
    assign obs_v[1] = bus1.dout_valid;
    assign obs_d[1] = bus1.dout_data;
    assign obs_o[1] = bus1.overrun;
    assign obs_r[1] = bus1.din_ready;

    // Reference model, one copy per instance (0: fresh-only, 1: any-seen).
    logic [DIN-1:0] m_reg[2][N];
    bit             m_fresh[2][N];
    bit             m_seen[2][N];
    logic [N-1:0]   m_ovr[2];
    int             m_ptr[2];
    bit             m_ov[2];
    int             m_oid[2];
    logic [DIN-1:0] m_odat[2];

    // Starvation tracking on the fresh-only instance, from observed beats.
    bit pend[N];
    int wt[N];
    int maxw;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                m_reg[d][i]   = '0;
                m_fresh[d][i] = 1'b0;
                m_seen[d][i]  = 1'b0;
            end
            m_ovr[d]  = '0;
            m_ptr[d]  = 0;
            m_ov[d]   = 1'b0;
            m_oid[d]  = 0;
            m_odat[d] = '0;
        end
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            wt[i]   = 0;
        end
        maxw = 0;
    endtask

    // One clock edge of the model: the next channel in rotation that holds
    // something to offer gets the output slot whenever the slot frees up.
    task automatic model_edge(input int d);
        bit load;
        bit found;
        bit taken;
        int g;
        int c;
        load  = !m_ov[d] || rdy;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr[d] + k) % N;
            if (!found && ((d == 0) ? m_fresh[d][c] : m_seen[d][c])) begin
                found = 1'b1;
                g     = c;
            end
        end
        if (load) begin
            if (found) begin
                m_oid[d]  = g;
                m_odat[d] = m_reg[d][g];
                m_ov[d]   = 1'b1;
                m_ptr[d]  = (g + 1) % N;
            end else begin
                m_ov[d] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            taken = load && found && (g == i);
            if (dv[i]) begin
                if (m_fresh[d][i] && !taken)
                    m_ovr[d][i] = 1'b1;
                m_reg[d][i]   = dd[i*DIN +: DIN];
                m_seen[d][i]  = 1'b1;
                m_fresh[d][i] = 1'b1;
            end else if (taken) begin
                m_fresh[d][i] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        logic [BW-1:0] e;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("valid%0d", d), 32'(obs_v[d]), 32'(m_ov[d]));
            if (m_ov[d]) begin
                e = {W'(m_oid[d]), m_odat[d]};
                chk($sformatf("data%0d", d), 32'(obs_d[d]), 32'(e));
            end
            chk($sformatf("overrun%0d", d), 32'(obs_o[d]), 32'(m_ovr[d]));
        end
    endtask

    // Advance one clock with the inputs currently driven, then check #1 later.
    task automatic cycle();
        bit pv0;
        int id;
        pv0 = obs_v[0];
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        if ((!pv0 || rdy) && obs_v[0]) begin
            id = int'(obs_d[0][BW-1:DIN]);
            for (int j = 0; j < N; j++) begin
                if (j != id && pend[j]) begin
                    wt[j]++;
                    if (wt[j] > maxw) maxw = wt[j];
                end
            end
            if (id < N) begin
                pend[id] = 1'b0;
                wt[id]   = 0;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (dv[j] && !pend[j]) begin
                pend[j] = 1'b1;
                wt[j]   = 0;
            end
        end
        check_all();
    endtask

    // Asynchronous reset pulse placed mid-cycle; effect checked before any edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_valid%0d", d), 32'(obs_v[d]), 32'(0));
            chk($sformatf("rst_data%0d", d), 32'(obs_d[d]), 32'(0));
            chk($sformatf("rst_overrun%0d", d), 32'(obs_o[d]), 32'(0));
            chk($sformatf("din_ready%0d", d), 32'(obs_r[d]), 32'({N{1'b1}}));
        end
        dv = '0;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        dv  = '0;
        dd  = '0;
        rdy = 1'b0;
        do_reset();

        // Single sample on ch1: one beat two cycles later, then idle.
        dv = 3'b010; dd = 24'h005A00; rdy = 1'b1;
        cycle();
        dv = '0;
        cycle();
        chk("t1_beat", 32'(obs_d[0]), 32'h15A);
        cycle();
        chk("t1_idle", 32'(obs_v[0]), 32'(0));

        // All three sampled together: emitted in id order 0,1,2.
        do_reset();
        dv = 3'b111; dd = 24'h121110; rdy = 1'b1;
        cycle();
        dv = '0;
        cycle();
        chk("t2_id0", 32'(obs_d[0]), 32'h010);
        cycle();
        chk("t2_id1", 32'(obs_d[0]), 32'h111);
        cycle();
        chk("t2_id2", 32'(obs_d[0]), 32'h212);

        // Stalled consumer: offered beat holds while ch0 keeps overwriting.
        do_reset();
        rdy = 1'b0;
        dv = 3'b001;
        for (int s = 1; s <= 5; s++) begin
            dd = 24'(s);
            cycle();
        end
        dv = '0;
        cycle();
        cycle();
        chk("t3_hold", 32'(obs_d[0]), 32'h001);
        chk("t3_hold_v", 32'(obs_v[0]), 32'(1));
        rdy = 1'b1;
        cycle();
        chk("t3_latest", 32'(obs_d[0]), 32'h005);
        chk("t3_overrun", 32'(obs_o[0][0]), 32'(1));

        // Any-seen mode: lone ch2 sample repeats every cycle without overrun.
        do_reset();
        dv = 3'b100; dd = 24'h330000; rdy = 1'b1;
        cycle();
        dv = '0;
        for (int r = 0; r < 6; r++) begin
            cycle();
            chk("t4_repeat", 32'(obs_d[1]), 32'h233);
            chk("t4_no_ovr", 32'(obs_o[1]), 32'(0));
        end

        // Reset while a beat is offered and overrun is set; pointer restarts at 0.
        do_reset();
        rdy = 1'b0;
        dv = 3'b010;
        for (int s = 1; s <= 3; s++) begin
            dd = {8'h00, 8'(8'h20 + s), 8'h00};
            cycle();
        end
        dv = '0;
        chk("t5_pre_v", 32'(obs_v[0]), 32'(1));
        chk("t5_pre_ovr", 32'(obs_o[0][1]), 32'(1));
        do_reset();
        dv = 3'b101; dd = 24'h420040; rdy = 1'b1;
        cycle();
        dv = '0;
        cycle();
        chk("t5_first", 32'(obs_d[0]), 32'h040);
        cycle();
        chk("t5_second", 32'(obs_d[0]), 32'h242);

        // Grant collides with a new sample on the same channel.
        do_reset();
        dv = 3'b001; dd = 24'h000011; rdy = 1'b1;
        cycle();
        dd = 24'h0000AA;
        cycle();
        chk("t6_old", 32'(obs_d[0]), 32'h011);
        chk("t6_no_ovr", 32'(obs_o[0][0]), 32'(0));
        dv = '0;
        cycle();
        chk("t6_new", 32'(obs_d[0]), 32'h0AA);

        // Random traffic with random back-pressure; fairness across it.
        do_reset();
        for (int r = 0; r < 200; r++) begin
            dv  = N'($urandom & $urandom);
            dd  = (N*DIN)'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end
        chk("starve", 32'(maxw <= N - 1), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
